// File: rtl/hearts_hud_ctrl.sv
// rtl/hearts_hud_ctrl.sv - lives counter and heart-row HUD sequencer with blink FSM
// Optional define HEART_LOW_WARN_EN: slot 0 blinks continuously while idle at one life.
module hearts_hud_ctrl #(
  parameter int MAX_LIVES     = 5,
  parameter int INIT_LIVES    = 3,
  parameter int TOP_LEFT_X    = 16,
  parameter int TOP_LEFT_Y    = 8,
  parameter int SPACING       = 20,
  parameter int BLINK_PERIOD  = 8,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        lifeLost,
  input  logic        lifeGained,
  input  logic        gameRestart,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [2:0]  livesCount,
  output logic        gameOver
);

  typedef enum logic [1:0] {IDLE, BLINK_LOSS, BLINK_GAIN, GAME_OVER} state_t;

  localparam logic [10:0] X0    = 11'(TOP_LEFT_X);
  localparam logic [10:0] Y0    = 11'(TOP_LEFT_Y);
  localparam logic [10:0] ROW_W = 11'(MAX_LIVES * SPACING);

  state_t      state;
  logic [2:0]  blink_slot;
  logic        blink_on;
  logic [15:0] frame_cnt;
  logic [15:0] toggle_cnt;

  logic [10:0] dx, dy, local_x;
  logic [2:0]  slot;
  logic        in_row, vis, hit, blinking, warn, lose_ok, gain_ok;

  assign dx     = pixelX - X0;
  assign dy     = pixelY - Y0;
  assign in_row = (pixelX >= X0) && (dx < ROW_W) && (pixelY >= Y0) && (dy < 11'd16);

  // Unrolled slot search: the last slot origin not beyond dx wins.
  always_comb begin
    slot    = 3'd0;
    local_x = dx;
    for (int i = 1; i < MAX_LIVES; i++) begin
      if (dx >= 11'(i * SPACING)) begin
        slot    = 3'(i);
        local_x = dx - 11'(i * SPACING);
      end
    end
  end

  assign blinking = (state == BLINK_LOSS) || (state == BLINK_GAIN);
`ifdef HEART_LOW_WARN_EN
  assign warn = (state == IDLE) && (livesCount == 3'd1);
`else
  assign warn = 1'b0;
`endif

  always_comb begin
    vis = 1'b0;
    if (state != GAME_OVER) begin
      if (blinking && slot == blink_slot)
        vis = blink_on;
      else if (warn && slot == 3'd0)
        vis = blink_on;
      else
        vis = slot < livesCount;
    end
  end

  assign hit     = in_row && (local_x < 11'd16) && vis;
  assign lose_ok = lifeLost && !lifeGained && (state != GAME_OVER) && (livesCount != 3'd0);
  assign gain_ok = lifeGained && !lifeLost && (state != GAME_OVER) && (livesCount < 3'(MAX_LIVES));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= IDLE;
      livesCount      <= 3'(INIT_LIVES);
      blink_slot      <= 3'd0;
      blink_on        <= 1'b1;
      frame_cnt       <= '0;
      toggle_cnt      <= '0;
      offsetX         <= '0;
      offsetY         <= '0;
      InsideRectangle <= 1'b0;
      gameOver        <= 1'b0;
    end else begin
      InsideRectangle <= hit;
      offsetX         <= hit ? local_x : 11'd0;
      offsetY         <= hit ? dy : 11'd0;

      if (gameRestart) begin
        state      <= IDLE;
        livesCount <= 3'(INIT_LIVES);
        blink_on   <= 1'b1;
        frame_cnt  <= '0;
        toggle_cnt <= '0;
        gameOver   <= 1'b0;
      end else if (lose_ok) begin
        livesCount <= livesCount - 3'd1;
        blink_slot <= livesCount - 3'd1;
        blink_on   <= 1'b1;
        frame_cnt  <= '0;
        toggle_cnt <= '0;
        state      <= BLINK_LOSS;
      end else if (gain_ok) begin
        livesCount <= livesCount + 3'd1;
        blink_slot <= livesCount;
        blink_on   <= 1'b0;
        frame_cnt  <= '0;
        toggle_cnt <= '0;
        state      <= BLINK_GAIN;
      end else if (blinking || warn) begin
        if (startOfFrame) begin
          if (frame_cnt == 16'(BLINK_PERIOD - 1)) begin
            frame_cnt <= '0;
            blink_on  <= ~blink_on;
            if (blinking) begin
              if (toggle_cnt == 16'(BLINK_TOGGLES - 1)) begin
                // Sequence done: visibility now follows livesCount alone.
                toggle_cnt <= '0;
                blink_on   <= 1'b1;
                if (state == BLINK_LOSS && livesCount == 3'd0) begin
                  state    <= GAME_OVER;
                  gameOver <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end else begin
                toggle_cnt <= toggle_cnt + 16'd1;
              end
            end
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
      end else if (state == IDLE) begin
        blink_on   <= 1'b1;
        frame_cnt  <= '0;
        toggle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hearts_hud_ctrl.sv
// tb/tb_hearts_hud_ctrl.sv - directed self-checking bench for hearts_hud_ctrl
module tb_hearts_hud_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        lifeLost = 1'b0;
  logic        lifeGained = 1'b0;
  logic        gameRestart = 1'b0;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle;
  logic [2:0]  livesCount;
  logic        gameOver;

  int checks = 0;
  int failures = 0;

  hearts_hud_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .lifeLost(lifeLost), .lifeGained(lifeGained), .gameRestart(gameRestart),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .livesCount(livesCount), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic l, input logic g, input logic r);
    lifeLost = l; lifeGained = g; gameRestart = r;
    tick();
    lifeLost = 1'b0; lifeGained = 1'b0; gameRestart = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input logic ins, input int ox, input int oy);
    pixelX = 11'(x); pixelY = 11'(y);
    tick();
    chk({tag, "_inside"}, 32'(InsideRectangle), 32'(ins));
    chk({tag, "_offx"}, 32'(offsetX), 32'(ox));
    chk({tag, "_offy"}, 32'(offsetY), 32'(oy));
  endtask

  initial begin
    tick(); tick();
    chk("rst_lives", 32'(livesCount), 32'd3);
    chk("rst_inside", 32'(InsideRectangle), 32'd0);
    chk("rst_gameover", 32'(gameOver), 32'd0);
    chk("rst_offx", 32'(offsetX), 32'd0);
    resetN = 1'b1;
    tick();

    // Geometry at three lives
    pix("slot0_origin", 16, 8, 1'b1, 0, 0);
    pix("slot2_corner", 71, 23, 1'b1, 15, 15);
    pix("gap", 72, 8, 1'b0, 0, 0);
    pix("slot3_unowned", 76, 8, 1'b0, 0, 0);
    pix("below_row", 16, 24, 1'b0, 0, 0);
    pix("left_of_row", 15, 8, 1'b0, 0, 0);

    // Loss blink on slot 2: 8 frames on, 8 off, six toggles, then hidden
    pulse(1'b1, 1'b0, 1'b0);
    chk("loss_lives", 32'(livesCount), 32'd2);
    pix("loss_f0", 56, 8, 1'b1, 0, 0);
    for (int f = 1; f <= 50; f++) begin
      frames(1);
      pixelX = 11'd56; pixelY = 11'd8;
      tick();
      if (f == 7 || f == 8 || f == 16 || f == 40 || f == 47 || f == 48 || f == 50)
        chk($sformatf("loss_f%0d", f), 32'(InsideRectangle),
            32'((f < 48) && ((f / 8) % 2 == 0)));
    end
    pix("loss_slot1_kept", 36, 8, 1'b1, 0, 0);

    // Run down to game over from three lives
    pulse(1'b0, 1'b0, 1'b1);
    chk("restart1_lives", 32'(livesCount), 32'd3);
    pulse(1'b1, 1'b0, 1'b0); frames(60);
    pulse(1'b1, 1'b0, 1'b0); frames(60);
    pulse(1'b1, 1'b0, 1'b0);
    chk("zero_lives", 32'(livesCount), 32'd0);
    frames(10);
    chk("go_during_blink", 32'(gameOver), 32'd0);
    frames(50);
    chk("game_over", 32'(gameOver), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("go_ignore_lives", 32'(livesCount), 32'd0);
    chk("go_held", 32'(gameOver), 32'd1);
    pix("go_no_hearts", 16, 8, 1'b0, 0, 0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("restart2_lives", 32'(livesCount), 32'd3);
    chk("restart2_go", 32'(gameOver), 32'd0);
    pix("restart2_slot0", 16, 8, 1'b1, 0, 0);

    // Gains: blink starts hidden, a second gain finalises the first slot
    pulse(1'b0, 1'b1, 1'b0);
    chk("gain1_lives", 32'(livesCount), 32'd4);
    pix("gain1_slot3_off", 76, 8, 1'b0, 0, 0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("gain2_lives", 32'(livesCount), 32'd5);
    pix("gain2_slot3_final", 76, 8, 1'b1, 0, 0);
    pix("gain2_slot4_off", 96, 8, 1'b0, 0, 0);
    frames(8);
    pix("gain2_slot4_on", 96, 8, 1'b1, 0, 0);
    frames(40);
    pix("gain2_slot4_steady", 99, 10, 1'b1, 3, 2);
    pulse(1'b0, 1'b1, 1'b0);
    chk("gain_at_max", 32'(livesCount), 32'd5);
    pix("gain_at_max_slot4", 96, 8, 1'b1, 0, 0);

    // Simultaneous loss and gain cancel
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b1, 1'b0);
    chk("both_lives", 32'(livesCount), 32'd3);
    pix("both_slot2", 56, 8, 1'b1, 0, 0);
    frames(8);
    pix("both_no_blink", 56, 8, 1'b1, 0, 0);

    // Asynchronous reset in the middle of a gain blink
    pulse(1'b0, 1'b1, 1'b0);
    chk("gain3_lives", 32'(livesCount), 32'd4);
    frames(3);
    pix("pre_reset", 71, 23, 1'b1, 15, 15);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_lives", 32'(livesCount), 32'd3);
    chk("async_inside", 32'(InsideRectangle), 32'd0);
    chk("async_offx", 32'(offsetX), 32'd0);
    chk("async_offy", 32'(offsetY), 32'd0);
    tick();
    resetN = 1'b1;
    pix("post_reset_slot3", 76, 8, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
